// File: rtl/key_filter_pkg.sv
// rtl/key_filter_pkg.sv - shared types and constants for the key_filter block
// Purpose: per-channel FSM state encoding and the channel count.
package key_filter_pkg;

  localparam int KEY_NUM = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_filter_chan.sv
// rtl/key_filter_chan.sv - one push-button channel: synchronizer, debounce FSM, long-press counter
// Purpose: condition one raw active-low key into a clean level plus press/release/long pulses.
// Ports:
//   sys_clk     - system clock
//   sys_rst     - synchronous active-high reset
//   key_in      - raw key, asynchronous, 0 = pressed
//   key_level   - debounced state, 1 = pressed
//   key_press   - one-cycle pulse on debounced press
//   key_release - one-cycle pulse on debounced release
//   key_long    - one-cycle pulse when a press has lasted LONG_MAX cycles
// Build option: KEY_FILTER_LONG_PRESS_EN enables the long-press counter; otherwise key_long is 0.
module key_filter_chan
  import key_filter_pkg::*;
#(
  parameter logic [23:0] CNT_MAX  = 24'd1_000_000,
  parameter logic [27:0] LONG_MAX = 28'd50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CW = (CNT_MAX > 24'd1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 24'd1);

  logic          s1;
  logic          s2;
  key_state_t    state;
  logic [CW-1:0] cnt;
  logic          press_hit;

  // Debounce completes on this cycle: the press is accepted at this edge.
  assign press_hit = (state == PRESS_DEB) && !s2 && (cnt == CNT_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1          <= 1'b1;
      s2          <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      s1          <= key_in;
      s2          <= s1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        IDLE: begin
          if (!s2) begin
            state <= PRESS_DEB;
            cnt   <= '0;
          end
        end
        PRESS_DEB: begin
          if (s2) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state     <= HELD;
            key_press <= 1'b1;
            key_level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (s2) begin
            state <= REL_DEB;
            cnt   <= '0;
          end
        end
        REL_DEB: begin
          if (!s2) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state       <= IDLE;
            key_release <= 1'b1;
            key_level   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_FILTER_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_MAX) + 1;
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 28'd1);

  logic [LW-1:0] lcnt;

  // lcnt stops at LONG_LAST, so key_long fires once per press and only a new
  // press (which clears lcnt) can arm it again.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      lcnt     <= '0;
      key_long <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (press_hit) begin
        lcnt     <= '0;
        key_long <= (LONG_LAST == '0);
      end else if (((state == HELD) || (state == REL_DEB)) && (lcnt != LONG_LAST)) begin
        lcnt     <= lcnt + 1'b1;
        key_long <= ((lcnt + 1'b1) == LONG_LAST);
      end
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_filter.sv
// rtl/key_filter.sv - four-channel push-button input conditioner
// Purpose: KEY_NUM independent key_filter_chan instances; outputs are concatenated per bit.
// Ports:
//   sys_clk     - system clock
//   sys_rst     - synchronous active-high reset
//   key_in      - raw keys, asynchronous, active-low
//   key_level   - debounced states, 1 = pressed
//   key_press   - per-key one-cycle press pulses
//   key_release - per-key one-cycle release pulses
//   key_long    - per-key one-cycle long-press pulses
// Build option: KEY_FILTER_LONG_PRESS_EN enables long-press detection.
module key_filter
  import key_filter_pkg::*;
#(
  parameter logic [23:0] CNT_MAX  = 24'd1_000_000,
  parameter logic [27:0] LONG_MAX = 28'd50_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
    key_filter_chan #(
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX)
    ) u_chan (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_in      (key_in[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_filter.sv
// tb/tb_key_filter.sv - directed self-checking bench for key_filter
module tb_key_filter;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] key_in;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  int n_checks = 0;
  int n_fail   = 0;

  int press_cnt[4]   = '{0, 0, 0, 0};
  int release_cnt[4] = '{0, 0, 0, 0};
  int long_cnt[4]    = '{0, 0, 0, 0};

`ifdef KEY_FILTER_LONG_PRESS_EN
  localparam logic LONG_ON = 1'b1;
`else
  localparam logic LONG_ON = 1'b0;
`endif

  key_filter #(
    .CNT_MAX  (24'd24),
    .LONG_MAX (28'd100)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      press_cnt[i]   <= press_cnt[i] + int'(key_press[i]);
      release_cnt[i] <= release_cnt[i] + int'(key_release[i]);
      long_cnt[i]    <= long_cnt[i] + int'(key_long[i]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int p_snap;
  int r_snap;

  initial begin
    sys_rst = 1'b1;
    key_in  = 4'hF;
    tick(10);
    chk("reset_level",   32'(key_level),   32'h0);
    chk("reset_press",   32'(key_press),   32'h0);
    chk("reset_release", 32'(key_release), 32'h0);
    chk("reset_long",    32'(key_long),    32'h0);
    sys_rst = 1'b0;
    tick(5);

    // Clean press and release on key 0; drive point is between edges e and e+1.
    key_in[0] = 1'b0;
    tick(26);
    chk("k0_press_early", 32'(key_press[0]), 32'h0);
    chk("k0_level_early", 32'(key_level[0]), 32'h0);
    tick(1);
    chk("k0_press_on",    32'(key_press),    32'h1);
    chk("k0_level_on",    32'(key_level[0]), 32'h1);
    tick(1);
    chk("k0_press_off",   32'(key_press[0]), 32'h0);
    chk("k0_level_hold",  32'(key_level[0]), 32'h1);
    tick(97);
    chk("k0_long_early",  32'(key_long[0]),  32'h0);
    tick(1);
    chk("k0_long_on",     32'(key_long[0]),  32'(LONG_ON));
    tick(1);
    chk("k0_long_off",    32'(key_long[0]),  32'h0);
    tick(73);
    key_in[0] = 1'b1;
    tick(26);
    chk("k0_rel_early",   32'(key_release[0]), 32'h0);
    chk("k0_level_pre",   32'(key_level[0]),   32'h1);
    tick(1);
    chk("k0_rel_on",      32'(key_release),    32'h1);
    chk("k0_level_off",   32'(key_level[0]),   32'h0);
    tick(1);
    chk("k0_rel_off",     32'(key_release[0]), 32'h0);
    tick(2);
    chk("k0_long_count",  32'(long_cnt[0]),    32'(LONG_ON));
    chk("k0_press_count", 32'(press_cnt[0]),   32'h1);

    // Bounce on key 1: 5-cycle toggles are rejected, then a settled press.
    p_snap = press_cnt[1];
    for (int i = 0; i < 20; i++) begin
      key_in[1] = ~key_in[1];
      tick(5);
    end
    chk("k1_bounce_press", 32'(press_cnt[1]),  32'(p_snap));
    chk("k1_bounce_level", 32'(key_level[1]),  32'h0);
    key_in[1] = 1'b0;
    tick(26);
    chk("k1_press_early",  32'(key_press[1]),  32'h0);
    tick(1);
    chk("k1_press_on",     32'(key_press),     32'h2);
    key_in[1] = 1'b1;
    tick(30);
    chk("k1_press_count",  32'(press_cnt[1]),  32'(p_snap + 1));
    chk("k1_rel_count",    32'(release_cnt[1]), 32'h1);

    // Short press on key 2 stays invisible.
    key_in[2] = 1'b0;
    tick(20);
    key_in[2] = 1'b1;
    tick(40);
    chk("k2_short_press", 32'(press_cnt[2]),   32'h0);
    chk("k2_short_rel",   32'(release_cnt[2]), 32'h0);
    chk("k2_short_level", 32'(key_level[2]),   32'h0);

    // All four keys pressed on the same edge.
    key_in = 4'b0000;
    tick(26);
    chk("all_press_early", 32'(key_press), 32'h0);
    tick(1);
    chk("all_press_on",    32'(key_press), 32'hF);
    tick(1);
    chk("all_press_off",   32'(key_press), 32'h0);
    chk("all_level",       32'(key_level), 32'hF);

    // Keep key 3 held, release the rest, then reset mid-hold.
    key_in = 4'b0111;
    tick(30);
    chk("k3_level_held", 32'(key_level), 32'h8);
    r_snap = release_cnt[3];
    sys_rst = 1'b1;
    tick(1);
    chk("rst_mid_level",   32'(key_level),   32'h0);
    chk("rst_mid_release", 32'(key_release), 32'h0);
    tick(3);
    sys_rst = 1'b0;
    tick(26);
    chk("k3_repress_early", 32'(key_press[3]), 32'h0);
    tick(1);
    chk("k3_repress_on",    32'(key_press),    32'h8);
    chk("k3_no_release",    32'(release_cnt[3]), 32'(r_snap));
    key_in = 4'hF;
    tick(30);
    chk("final_level",      32'(key_level),    32'h0);
    chk("long_other_keys",  32'(long_cnt[1] + long_cnt[2] + long_cnt[3]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_filter.md
# key_filter

Four-channel push-button input conditioner: the input-side counterpart to the LED output blocks. Each raw, bouncing, active-low key is synchronised to `sys_clk`, debounced with a stable-time counter, and turned into a clean level plus single-cycle press, release and long-press pulses. Downstream pattern and flow controllers consume these pulses, for example to change LED direction or speed.

## Interface
- `CNT_MAX`, default 24'd1_000_000: debounce stable time in `sys_clk` cycles (20 ms at 50 MHz); benches use 24'd24; must be ≥1.
- `LONG_MAX`, default 28'd50_000_000: held cycles, counted from `key_press`, before `key_long` fires (1 s); must be ≥1.
- `sys_clk`, input, 1: system clock, 50 MHz.
- `sys_rst`, input, 1: reset, synchronous, active-high.
- `key_in`, input, 4: raw keys, asynchronous, active-low (0 = pressed).
- `key_level`, output, 4: debounced state, 1 = pressed.
- `key_press`, output, 4: one-cycle pulse on debounced press.
- `key_release`, output, 4: one-cycle pulse on debounced release.
- `key_long`, output, 4: one-cycle pulse when a press lasts `LONG_MAX` cycles.

## Operation
- **Channel independence:** the four channels are identical and independent. Simultaneous activity on several keys gives simultaneous, uncorrelated pulses.
- **Synchronizer:** two flops per key, `s1` then `s2`. Both reset to 1 (released).
- **Per-channel FSM states:** IDLE, PRESS_DEB, HELD, REL_DEB.
  - IDLE: if `s2`=0, go to PRESS_DEB and clear `cnt`.
  - PRESS_DEB, `s2`=1: bounce, so return to IDLE with no output.
  - PRESS_DEB, `s2`=0 and `cnt`==CNT_MAX-1: go to HELD, assert `key_press`, set `key_level`=1, clear `lcnt`.
  - PRESS_DEB, otherwise: increment `cnt`.
  - HELD: if `s2`=1, go to REL_DEB and clear `cnt`.
  - REL_DEB, `s2`=0: bounce, so return to HELD with no output. `lcnt` keeps its value.
  - REL_DEB, `s2`=1 and `cnt`==CNT_MAX-1: go to IDLE, assert `key_release`, set `key_level`=0.
  - REL_DEB, otherwise: increment `cnt`.
- **Long-press counter:** `lcnt` increments in HELD and REL_DEB and saturates. `key_long` is pulsed exactly once, on the cycle `lcnt` reaches LONG_MAX-1. It is not re-armed until the next `key_press`.
- **Counter widths:** `cnt` is `$clog2(CNT_MAX)` bits, minimum 1. `lcnt` is `$clog2(LONG_MAX)+1` bits. Neither counter ever wraps.
- **Reset values:** all outputs 0, state IDLE, counters 0.
- **Reset during activity:** mid-press or mid-hold, the channel goes straight to IDLE with no `key_release` pulse. A key still held when reset deasserts is reported as a fresh press after the full debounce time.

## Timing
- All outputs are registered.
- **Press latency:** let edge k be the first `sys_clk` edge at which `s1` captures 0.
  - `s2`=0 after edge k+1.
  - Enter PRESS_DEB at edge k+2.
  - `key_press` and `key_level` rise at edge k+2+CNT_MAX; the pulse lasts one cycle.
- **Release latency:** symmetric to press latency; `key_release` rises at edge k+2+CNT_MAX.
- **Long-press timing:** `key_long` rises LONG_MAX-1 edges after `key_press` rises.
- **Bounce rejection:** any bounce shorter than CNT_MAX cycles produces no output.

## Configuration
- **`KEY_FILTER_LONG_PRESS_EN` defined:** `lcnt` and `key_long` are implemented as described above.
- **`KEY_FILTER_LONG_PRESS_EN` undefined:** no `lcnt`; `key_long` is tied to 4'b0000. All other behaviour is unchanged.

## Structure
- **Package `key_filter_pkg`:** FSM state enum `key_state_t` (IDLE, PRESS_DEB, HELD, REL_DEB) and the `KEY_NUM`=4 constant.
- **Sub-module `key_filter_chan`:** one channel, covering synchronizer, FSM and counters. It is instantiated `KEY_NUM` times with a generate loop; the top level only concatenates the outputs.

## Test plan
Bench settings: CNT_MAX=24, LONG_MAX=100, 20 ns clock, `sys_rst` high for 10 cycles.
- **Clean press and release:** `key_in[0]` held 0 for 200 cycles, then 1.
  - `key_press[0]` pulses one cycle at k+26.
  - `key_level[0]` is high from k+26.
  - `key_release[0]` pulses 26 edges after release.
  - `key_long[0]` pulses once, 99 edges after `key_press[0]`.
- **Bounce rejection:** `key_in[1]` toggles every 5 cycles for 100 cycles, then stays 0.
  - No pulses during the toggling.
  - One `key_press[1]`, 26 edges after the final settle.
- **Short press:** `key_in[2]` held 0 for 20 cycles.
  - All outputs stay 0.
- **Simultaneous keys:** `key_in`=4'b0000 driven on the same edge.
  - `key_press`=4'b1111 on one cycle, then 0.
- **Reset mid-hold:** `sys_rst` pulsed while `key_level[3]`=1 and `key_in[3]` still 0.
  - Outputs drop to 0 with no release pulse.
  - `key_press[3]` re-fires 26 edges after the first sampling edge following reset release.
- **Macro undefined:** rerun the clean press-and-release scenario without `KEY_FILTER_LONG_PRESS_EN`.
  - `key_long` stays 0; all other results are identical.
